// File: rtl/mul_sos_param_pkg.sv
// Shared definitions for the SOS multi-precision multiplier: state encoding,
// a constant-function clog2 and the parameter legality check.
package mul_sos_param_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StMul   = 2'd1,
    StFlush = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

  // Operand width must split into whole words and whole lane groups.
  function automatic bit params_legal(input int unsigned dw, input int unsigned ww,
                                      input int unsigned lanes);
    if (dw == 0 || ww == 0 || lanes == 0) return 1'b0;
    return (dw % (ww * lanes)) == 0;
  endfunction

endpackage

// File: rtl/mul_sos_param_mul_ww_wrapper.sv
// WW x WW -> 2WW combinational word multiplier; the single place to drop in a
// vendor multiplier macro.
module mul_ww_wrapper #(
  parameter int unsigned WW = 64
) (
  input  logic [WW-1:0]   a,
  input  logic [WW-1:0]   b,
  output logic [2*WW-1:0] p
);

  assign p = {{WW{1'b0}}, a} * {{WW{1'b0}}, b};

endmodule

// File: rtl/mul_sos_param.sv
// Full-width unsigned multiplier, separated operand scanning with LANES word
// multipliers working on adjacent columns of B; valid/ready on both sides.
module mul_sos_param
  import mul_sos_param_pkg::*;
#(
  parameter int unsigned DW    = 256,
  parameter int unsigned WW    = 64,
  parameter int unsigned LANES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   b_i,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [2*DW-1:0] r_o
);

  localparam int unsigned N  = DW / WW;
  localparam int unsigned G  = N / LANES;
  localparam int unsigned NR = 2 * N;
  localparam int unsigned IW = (clog2(N) > 0) ? clog2(N) : 1;
  localparam int unsigned GW = (clog2(G) > 0) ? clog2(G) : 1;
  localparam int unsigned RW = clog2(NR);
  localparam int unsigned SW = (LANES + 1) * WW;

  if (!params_legal(DW, WW, LANES)) begin : g_param_check
    $error("mul_sos_param: DW must be a non-zero multiple of WW*LANES");
  end

  state_e state_q, state_d;

  logic [WW-1:0] a_q [N];
  logic [WW-1:0] a_d [N];
  logic [WW-1:0] b_q [N];
  logic [WW-1:0] b_d [N];
  logic [WW-1:0] r_q [NR];
  logic [WW-1:0] r_d [NR];
  logic [WW-1:0] carry_q [LANES];
  logic [WW-1:0] carry_d [LANES];

  logic [IW-1:0] i_q, i_d;
  logic [GW-1:0] grp_q, grp_d;

  logic [IW-1:0]   j_idx [LANES];
  logic [RW-1:0]   col   [LANES];
  logic [2*WW-1:0] prod  [LANES];
  logic [2*WW-1:0] sum   [LANES];

  logic [SW-1:0] seg_old, seg_add, seg_new;

  // Lane l owns row j = grp*LANES + l and writes column i + j this step.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign j_idx[l] = IW'(32'(grp_q) * LANES + l);
    assign col[l]   = RW'(32'(i_q) + 32'(j_idx[l]));

    mul_ww_wrapper #(
      .WW(WW)
    ) u_mul (
      .a(a_q[i_q]),
      .b(b_q[j_idx[l]]),
      .p(prod[l])
    );

    // Max is (2^WW-1)^2 + 2(2^WW-1) = 2^(2WW)-1, so the sum never overflows.
    assign sum[l] = prod[l] + {{WW{1'b0}}, r_q[col[l]]} + {{WW{1'b0}}, carry_q[l]};
  end

  // Lane carries sit at columns N+grp*LANES+l; fold them in with one adder.
  // The top word of the last group's segment lies past R and is always zero.
  always_comb begin
    seg_old = '0;
    seg_add = '0;
    for (int unsigned k = 0; k <= LANES; k++) begin
      if (N + 32'(grp_q) * LANES + k < NR) begin
        seg_old[k*WW +: WW] = r_q[RW'(N + 32'(grp_q) * LANES + k)];
      end
    end
    for (int unsigned l = 0; l < LANES; l++) begin
      seg_add[l*WW +: WW] = carry_q[l];
    end
    seg_new = seg_old + seg_add;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    carry_d = carry_q;
    i_d     = i_q;
    grp_d   = grp_q;

    unique case (state_q)
      StIdle: begin
        if (in_vld) begin
          for (int unsigned k = 0; k < N; k++) begin
            a_d[k] = a_i[k*WW +: WW];
            b_d[k] = b_i[k*WW +: WW];
          end
          for (int unsigned k = 0; k < NR; k++) r_d[k] = '0;
          for (int unsigned l = 0; l < LANES; l++) carry_d[l] = '0;
          i_d     = '0;
          grp_d   = '0;
          state_d = StMul;
        end
      end

      StMul: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          r_d[col[l]] = sum[l][WW-1:0];
          carry_d[l]  = sum[l][2*WW-1:WW];
        end
        if (i_q == IW'(N - 1)) begin
          state_d = StFlush;
        end else begin
          i_d = i_q + 1'b1;
        end
      end

      StFlush: begin
        for (int unsigned k = 0; k <= LANES; k++) begin
          if (N + 32'(grp_q) * LANES + k < NR) begin
            r_d[RW'(N + 32'(grp_q) * LANES + k)] = seg_new[k*WW +: WW];
          end
        end
        for (int unsigned l = 0; l < LANES; l++) carry_d[l] = '0;
        i_d = '0;
        if (grp_q == GW'(G - 1)) begin
          state_d = StDone;
        end else begin
          grp_d   = grp_q + 1'b1;
          state_d = StMul;
        end
      end

      StDone: begin
        if (out_rdy) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      r_q     <= '{default: '0};
      carry_q <= '{default: '0};
      i_q     <= '0;
      grp_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      carry_q <= carry_d;
      i_q     <= i_d;
      grp_q   <= grp_d;
    end
  end

  assign in_rdy  = (state_q == StIdle);
  assign out_vld = (state_q == StDone);

  always_comb begin
    r_o = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      r_o[k*WW +: WW] = r_q[k];
    end
  end

endmodule

// File: tb/tb_mul_sos_param.sv
// Bench for mul_sos_param: directed scenarios on the default configuration and
// a randomized sweep over four parameter sets against wide-integer arithmetic.
module tb_mul_sos_param;

  localparam int unsigned DW    = 256;
  localparam int          LAT   = 10;
  localparam int          NRAND = 500;

  logic            clk;
  logic            rst_n;
  logic            in_vld, in_rdy, out_vld, out_rdy;
  logic [DW-1:0]   a, b;
  logic [2*DW-1:0] r;

  int n_cmp;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mul_sos_param u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vld (in_vld),
    .in_rdy (in_rdy),
    .a_i    (a),
    .b_i    (b),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .r_o    (r)
  );

  // ---------------------------------------------------------------- sweep cfgs
  function int cfg_dw(input int c);
    return (c == 2) ? 128 : (c == 3) ? 512 : 256;
  endfunction
  function int cfg_ww(input int c);
    return (c == 2) ? 32 : 64;
  endfunction
  function int cfg_lanes(input int c);
    return (c == 0) ? 1 : (c == 1) ? 4 : 2;
  endfunction
  function int cfg_lat(input int c);
    int nw;
    nw = cfg_dw(c) / cfg_ww(c);
    return (nw / cfg_lanes(c)) * (nw + 1);
  endfunction

  logic [511:0] sw_a, sw_b;
  int           sw_sel;
  int           req_cnt;
  wire [1023:0] res_w [4];
  wire [31:0]   cyc_w [4];
  wire [31:0]   ack_w [4];
  wire          rdy_w [4];

  for (genvar c = 0; c < 4; c++) begin : g_sweep
    localparam int unsigned CDW = cfg_dw(c);
    localparam int          CLAT = cfg_lat(c);

    logic             s_vld, s_rdy, s_ovld, s_ordy;
    logic [CDW-1:0]   sa, sb;
    logic [2*CDW-1:0] sr;
    int               cyc, ack;
    logic             rdy_seen;

    mul_sos_param #(
      .DW   (cfg_dw(c)),
      .WW   (cfg_ww(c)),
      .LANES(cfg_lanes(c))
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_vld (s_vld),
      .in_rdy (s_rdy),
      .a_i    (sa),
      .b_i    (sb),
      .out_vld(s_ovld),
      .out_rdy(s_ordy),
      .r_o    (sr)
    );

    assign res_w[c] = 1024'(sr);
    assign cyc_w[c] = cyc;
    assign ack_w[c] = ack;
    assign rdy_w[c] = rdy_seen;

    // Driver only: runs one operation per request and posts what it observed.
    initial begin
      int seen;
      seen = 0; ack = 0; cyc = 0; rdy_seen = 1'b0;
      s_vld = 1'b0; s_ordy = 1'b0; sa = '0; sb = '0;
      forever begin
        wait (req_cnt != seen && sw_sel == c);
        seen = req_cnt;
        @(negedge clk);
        sa = sw_a[CDW-1:0];
        sb = sw_b[CDW-1:0];
        s_vld = 1'b1;
        rdy_seen = s_rdy;
        @(posedge clk);
        #1 s_vld = 1'b0;
        cyc = 0;
        do begin
          @(posedge clk); #1;
          cyc++;
        end while (!s_ovld && cyc < CLAT + 20);
        if (!s_ovld) cyc = -1;
        @(negedge clk);
        s_ordy = 1'b1;
        @(posedge clk);
        #1 s_ordy = 1'b0;
        ack = seen;
      end
    end
  end

  // ------------------------------------------------------------ model/helpers
  function automatic logic [2*DW-1:0] model_mul(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int k = 0; k < 512; k += 32) v[k +: 32] = $urandom();
    return v;
  endfunction

  task automatic accept(input logic [DW-1:0] av, input logic [DW-1:0] bv, output int waits);
    @(negedge clk);
    a = av;
    b = bv;
    in_vld = 1'b1;
    waits = 0;
    while (!in_rdy && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_rdy) waits = -1;
    @(posedge clk);
    #1 in_vld = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_vld && cyc < limit);
    if (!out_vld) cyc = -1;
  endtask

  task automatic release_out();
    @(negedge clk);
    out_rdy = 1'b1;
    @(posedge clk);
    #1 out_rdy = 1'b0;
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; a = '0; b = '0;
    #2;
    n_cmp++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: in_rdy=%b out_vld=%b, required 1/0", in_rdy, out_vld);
    end
    n_cmp++;
    if (r !== '0) begin
      n_bad++;
      $display("FAIL reset_result: r=%h, required 0", r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: in_rdy=%b out_vld=%b, required 1/0", in_rdy, out_vld);
    end
  endtask

  task automatic test_all_ones();
    logic [DW-1:0] ones;
    logic [DW-1:0] exp_hi;
    int waits, cyc;
    ones = '1;
    exp_hi = ones - 1;
    accept(ones, ones, waits);
    wait_done(40, cyc);
    n_cmp++;
    if (cyc != LAT) begin
      n_bad++;
      $display("FAIL all_ones_latency: got %0d cycles, required %0d", cyc, LAT);
    end
    n_cmp++;
    if (r[2*DW-1:DW] !== exp_hi || r[DW-1:0] !== 256'd1) begin
      n_bad++;
      $display("FAIL all_ones_value: r=%h, required hi=%h lo=1", r, exp_hi);
    end
    release_out();
    n_cmp++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL all_ones_release: in_rdy=%b out_vld=%b, required 1/0", in_rdy, out_vld);
    end
  endtask

  task automatic test_zero_identity();
    logic [DW-1:0] xv;
    logic [2*DW-1:0] exp;
    int waits, cyc, busy_bad;
    xv = rand512()[DW-1:0];
    for (int pass = 0; pass < 2; pass++) begin
      exp = (pass == 0) ? '0 : {{DW{1'b0}}, xv};
      accept(DW'(pass), xv, waits);
      busy_bad = 0;
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
        if (in_rdy !== 1'b0) busy_bad++;
      end while (!out_vld && cyc < 40);
      n_cmp++;
      if (busy_bad != 0) begin
        n_bad++;
        $display("FAIL busy_in_rdy pass %0d: in_rdy high in %0d cycles, required 0", pass, busy_bad);
      end
      n_cmp++;
      if (cyc != LAT) begin
        n_bad++;
        $display("FAIL zero_id_latency pass %0d: got %0d, required %0d", pass, cyc, LAT);
      end
      n_cmp++;
      if (r !== exp) begin
        n_bad++;
        $display("FAIL zero_id_value pass %0d: r=%h, required %h", pass, r, exp);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] av, bv, na, nb;
    logic [2*DW-1:0] exp;
    int waits, cyc;
    av = rand512()[DW-1:0];
    bv = rand512()[DW-1:0];
    na = '0;
    nb = '0;
    exp = model_mul(av, bv);
    accept(av, bv, waits);
    wait_done(40, cyc);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      na = rand512()[DW-1:0];
      nb = rand512()[DW-1:0];
      a = na;
      b = nb;
      in_vld = (k % 2 == 0);
      @(posedge clk); #1;
      n_cmp++;
      if (out_vld !== 1'b1 || in_rdy !== 1'b0 || r !== exp) begin
        n_bad++;
        $display("FAIL hold cycle %0d: out_vld=%b in_rdy=%b r_lo=%h, required 1/0 r_lo=%h",
                 k, out_vld, in_rdy, r[DW-1:0], exp[DW-1:0]);
      end
    end
    @(negedge clk);
    in_vld = 1'b1;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    n_cmp++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: in_rdy=%b out_vld=%b, required 1/0", in_rdy, out_vld);
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
    n_cmp++;
    if (in_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_new_accept: in_rdy=%b, required 0", in_rdy);
    end
    wait_done(40, cyc);
    n_cmp++;
    if (cyc != LAT) begin
      n_bad++;
      $display("FAIL bp_new_latency: got %0d, required %0d", cyc, LAT);
    end
    n_cmp++;
    if (r !== model_mul(na, nb)) begin
      n_bad++;
      $display("FAIL bp_new_value: r=%h, required %h", r, model_mul(na, nb));
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] av, bv;
    int waits, cyc;
    accept(rand512()[DW-1:0], rand512()[DW-1:0], waits);
    // Edge E0+8 leaves group 1 at step 3.
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0 || r !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: in_rdy=%b out_vld=%b r=%h, required 1/0/0", in_rdy, out_vld, r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    av = rand512()[DW-1:0];
    bv = rand512()[DW-1:0];
    accept(av, bv, waits);
    wait_done(40, cyc);
    n_cmp++;
    if (cyc != LAT || r !== model_mul(av, bv)) begin
      n_bad++;
      $display("FAIL post_reset_op: cycles=%0d r=%h, required %0d %h",
               cyc, r, LAT, model_mul(av, bv));
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] av, bv;
    int waits, cyc;
    out_rdy = 1'b1;
    for (int t = 0; t < 4; t++) begin
      av = rand512()[DW-1:0];
      bv = rand512()[DW-1:0];
      accept(av, bv, waits);
      n_cmp++;
      if (waits != ((t == 0) ? 0 : 1)) begin
        n_bad++;
        $display("FAIL b2b_turnaround op %0d: waited %0d, required %0d", t, waits, (t == 0) ? 0 : 1);
      end
      wait_done(40, cyc);
      n_cmp++;
      if (cyc != LAT || r !== model_mul(av, bv)) begin
        n_bad++;
        $display("FAIL b2b_op %0d: cycles=%0d r=%h, required %0d %h",
                 t, cyc, r, LAT, model_mul(av, bv));
      end
    end
    @(posedge clk); #1;
    out_rdy = 1'b0;
    n_cmp++;
    if (in_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_end_idle: in_rdy=%b, required 1", in_rdy);
    end
  endtask

  task automatic test_param_sweep();
    logic [511:0]  av, bv, mask, one;
    logic [1023:0] exp;
    int w, k;
    one = 512'd1;
    for (int c = 0; c < 4; c++) begin
      w = cfg_dw(c);
      mask = {512{1'b1}} >> (512 - w);
      for (int t = 0; t < NRAND + 6; t++) begin
        av = rand512() & mask;
        bv = rand512() & mask;
        case (t)
          0: av = '0;
          1: av = one;
          2: begin av = mask; bv = mask; end
          3: av = one << $urandom_range(w - 1, 0);
          4: bv = one << $urandom_range(w - 1, 0);
          5: begin av = mask; bv = one; end
          default: ;
        endcase
        sw_a = av;
        sw_b = bv;
        sw_sel = c;
        req_cnt++;
        k = 0;
        while (int'(ack_w[c]) != req_cnt && k < 2000) begin
          @(posedge clk);
          k++;
        end
        n_cmp++;
        if (int'(ack_w[c]) != req_cnt) begin
          n_bad++;
          $display("FAIL sweep cfg %0d op %0d: no completion within %0d cycles", c, t, k);
          return;
        end
        exp = {512'd0, av} * {512'd0, bv};
        n_cmp++;
        if (res_w[c] !== exp) begin
          n_bad++;
          $display("FAIL sweep_value cfg %0d op %0d: r_lo=%h, required r_lo=%h",
                   c, t, res_w[c][255:0], exp[255:0]);
        end
        n_cmp++;
        if (int'(cyc_w[c]) != cfg_lat(c) || rdy_w[c] !== 1'b1) begin
          n_bad++;
          $display("FAIL sweep_timing cfg %0d op %0d: cycles=%0d in_rdy=%b, required %0d/1",
                   c, t, int'(cyc_w[c]), rdy_w[c], cfg_lat(c));
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    req_cnt = 0;
    sw_sel = -1;
    sw_a = '0;
    sw_b = '0;
    test_reset();
    test_all_ones();
    test_zero_identity();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
